mem_wb_stage: RTL and testbench

//  MEM stage plus MEM/WB register; sits directly downstream of the EX/MEM register.

---
 rtl/mem_wb_stage_pkg.sv | 23 ++
 rtl/mem_wb_stage_if.sv | 22 ++
 rtl/mem_wb_stage_branch_resolve.sv | 27 ++
 rtl/mem_wb_stage.sv | 205 ++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared widths, branch-condition codes, FSM states.
// No ports; imported by the MEM/WB stage, its interface and sub-blocks.
package mem_wb_stage_pkg;
   localparam int PC_W   = 22;
   localparam int REG_AW = 5;
   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [2:0] {
      BR_NEQ    = 3'b000,
      BR_EQ     = 3'b001,
      BR_GT     = 3'b010,
      BR_LT     = 3'b011,
      BR_GTE    = 3'b100,
      BR_LTE    = 3'b101,
      BR_OVF    = 3'b110,
      BR_UNCOND = 3'b111
   } br_cond_e;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory req/ack handshake bundle.
// master = MEM stage (req, we, addr, wdata out); slave = memory (rdata, ack out).
interface mem_wb_stage_if #(
   parameter int DMEM_AW = 16
) ();
   logic               req;
   logic               we;
   logic [DMEM_AW-1:0] addr;
   logic [31:0]        wdata;
   logic [31:0]        rdata;
   logic               ack;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack
   );
endinterface

// File: rtl/mem_wb_stage_branch_resolve.sv
// branch_resolve: combinational branch-condition evaluator.
// In: cond[2:0], flag_ov/neg/zero. Out: taken.
module branch_resolve
   import mem_wb_stage_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       flag_ov,
   input  logic       flag_neg,
   input  logic       flag_zero,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      unique case (br_cond_e'(cond))
         BR_NEQ:    taken = !flag_zero;
         BR_EQ:     taken = flag_zero;
         BR_GT:     taken = !flag_zero && !flag_neg;
         BR_LT:     taken = flag_neg;
         BR_GTE:    taken = !flag_neg;
         BR_LTE:    taken = flag_neg || flag_zero;
         BR_OVF:    taken = flag_ov;
         BR_UNCOND: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage + MEM/WB register; branch resolve, dmem req/ack, stall.
// In: clk, rst, hlt, MEM_* bundle; dmem master port; Out: stall/flush/target, mem_err, WB_*.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int DMEM_AW = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hlt,
   input  logic              MEM_valid,
   input  logic              MEM_mem_rd,
   input  logic              MEM_mem_wr,
   input  logic              MEM_is_branch,
   input  logic              MEM_use_dst,
   input  logic              MEM_flag_ov,
   input  logic              MEM_flag_neg,
   input  logic              MEM_flag_zero,
   input  logic [2:0]        MEM_branch_cond,
   input  logic [REG_AW-1:0] MEM_addr,
   input  logic [PC_W-1:0]   MEM_PC,
   input  logic [PC_W-1:0]   MEM_PC_out,
   input  logic [DATA_W-1:0] MEM_data,
   input  logic [DATA_W-1:0] MEM_st_data,
   mem_wb_stage_if.master    dmem,
   output logic              stall_out,
   output logic              flush_out,
   output logic [PC_W-1:0]   branch_target,
   output logic              mem_err,
   output logic              WB_valid,
   output logic              WB_we,
   output logic [REG_AW-1:0] WB_dst,
   output logic [DATA_W-1:0] WB_data,
   output logic [PC_W-1:0]   WB_PC
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [0:0]         state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [DMEM_AW-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               we_q, we_d;
   logic [REG_AW-1:0]  dst_q, dst_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               err_q, err_d;
   logic               pend_q, pend_d;
   logic [DATA_W-1:0]  pend_data_q, pend_data_d;
   logic               pend_we_q, pend_we_d;
   logic               wb_valid_q, wb_valid_d;
   logic               wb_we_q, wb_we_d;
   logic [REG_AW-1:0]  wb_dst_q, wb_dst_d;
   logic [DATA_W-1:0]  wb_data_q, wb_data_d;
   logic [PC_W-1:0]    wb_pc_q, wb_pc_d;

   logic in_idle, in_access, is_mem, accept;
   logic timeout, done, taken;
   logic [DATA_W-1:0] res_data;

   branch_resolve u_br (
      .cond      (MEM_branch_cond),
      .flag_ov   (MEM_flag_ov),
      .flag_neg  (MEM_flag_neg),
      .flag_zero (MEM_flag_zero),
      .taken     (taken)
   );

   assign in_idle   = (state_q == ST_IDLE);
   assign in_access = (state_q == ST_ACCESS);
   assign is_mem    = MEM_valid && (MEM_mem_rd || MEM_mem_wr)
                      && !MEM_is_branch;
   // A result parked during hlt must drain before the next access.
   assign accept    = in_idle && !pend_q && is_mem && !hlt;
   assign timeout   = in_access && !dmem.ack && (cnt_q == TO_LAST);
   assign done      = in_access && (dmem.ack || timeout);
   assign res_data  = timeout ? ERR_DATA : dmem.rdata;

   // Release upstream on the completing cycle so the op retires once.
   assign stall_out = in_access ? !done : (accept || pend_q);
   assign flush_out = MEM_valid && MEM_is_branch && taken
                      && !stall_out && !hlt;
   assign branch_target = flush_out ? MEM_PC_out : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      dst_d   = dst_q;
      pc_d    = pc_q;
      err_d   = err_q;
      if (in_idle) begin
         if (accept) begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            addr_d  = MEM_data[DMEM_AW-1:0];
            wdata_d = MEM_st_data;
            we_d    = MEM_mem_wr;
            dst_d   = MEM_addr;
            pc_d    = MEM_PC;
            if (MEM_mem_rd && MEM_mem_wr) err_d = 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 8'd1;
         if (done) state_d = ST_IDLE;
         if (timeout) err_d = 1'b1;
      end
   end

   always_comb begin
      wb_valid_d  = wb_valid_q;
      wb_we_d     = wb_we_q;
      wb_dst_d    = wb_dst_q;
      wb_data_d   = wb_data_q;
      wb_pc_d     = wb_pc_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      pend_we_d   = pend_we_q;
      // The handshake finishes under hlt; park the result until hlt drops.
      if (done && hlt) begin
         pend_d      = 1'b1;
         pend_data_d = res_data;
         pend_we_d   = !we_q;
      end
      if (!hlt) begin
         unique case (1'b1)
            done: begin
               wb_valid_d = 1'b1;
               wb_we_d    = !we_q;
               wb_dst_d   = dst_q;
               wb_data_d  = res_data;
               wb_pc_d    = pc_q;
            end
            pend_q: begin
               wb_valid_d = 1'b1;
               wb_we_d    = pend_we_q;
               wb_dst_d   = dst_q;
               wb_data_d  = pend_data_q;
               wb_pc_d    = pc_q;
               pend_d     = 1'b0;
            end
            (in_idle && !pend_q && MEM_valid && !is_mem): begin
               wb_valid_d = 1'b1;
               wb_we_d    = MEM_use_dst;
               wb_dst_d   = MEM_addr;
               wb_data_d  = MEM_data;
               wb_pc_d    = MEM_PC;
            end
            default: wb_valid_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         dst_q       <= '0;
         pc_q        <= '0;
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
         pend_we_q   <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_dst_q    <= '0;
         wb_data_q   <= '0;
         wb_pc_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         dst_q       <= dst_d;
         pc_q        <= pc_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         pend_we_q   <= pend_we_d;
         wb_valid_q  <= wb_valid_d;
         wb_we_q     <= wb_we_d;
         wb_dst_q    <= wb_dst_d;
         wb_data_q   <= wb_data_d;
         wb_pc_q     <= wb_pc_d;
      end
   end

   assign dmem.req   = in_access;
   assign dmem.we    = we_q;
   assign dmem.addr  = addr_q;
   assign dmem.wdata = wdata_q;
   assign mem_err    = err_q;
   assign WB_valid   = wb_valid_q;
   assign WB_we      = wb_we_q;
   assign WB_dst     = wb_dst_q;
   assign WB_data    = wb_data_q;
   assign WB_PC      = wb_pc_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage.
// Drives MEM_* and a scripted dmem responder; WB outputs checked against a queue.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hlt = 1'b0;
   logic        MEM_valid, MEM_mem_rd, MEM_mem_wr, MEM_is_branch;
   logic        MEM_use_dst, MEM_flag_ov, MEM_flag_neg, MEM_flag_zero;
   logic [2:0]  MEM_branch_cond;
   logic [4:0]  MEM_addr;
   logic [21:0] MEM_PC, MEM_PC_out;
   logic [31:0] MEM_data, MEM_st_data;
   logic        stall_out, flush_out, mem_err;
   logic [21:0] branch_target;
   logic        WB_valid, WB_we;
   logic [4:0]  WB_dst;
   logic [31:0] WB_data;
   logic [21:0] WB_PC;

   mem_wb_stage_if #(.DMEM_AW(16)) dmem ();

   mem_wb_stage #(.DMEM_AW(16), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .hlt(hlt),
      .MEM_valid(MEM_valid), .MEM_mem_rd(MEM_mem_rd),
      .MEM_mem_wr(MEM_mem_wr), .MEM_is_branch(MEM_is_branch),
      .MEM_use_dst(MEM_use_dst), .MEM_flag_ov(MEM_flag_ov),
      .MEM_flag_neg(MEM_flag_neg), .MEM_flag_zero(MEM_flag_zero),
      .MEM_branch_cond(MEM_branch_cond), .MEM_addr(MEM_addr),
      .MEM_PC(MEM_PC), .MEM_PC_out(MEM_PC_out),
      .MEM_data(MEM_data), .MEM_st_data(MEM_st_data),
      .dmem(dmem),
      .stall_out(stall_out), .flush_out(flush_out),
      .branch_target(branch_target), .mem_err(mem_err),
      .WB_valid(WB_valid), .WB_we(WB_we), .WB_dst(WB_dst),
      .WB_data(WB_data), .WB_PC(WB_PC)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  dst;
      logic [31:0] data;
      logic [21:0] pc;
      logic        chk_data;
   } wb_exp_t;

   wb_exp_t sb[$];
   int checks = 0;
   int errors = 0;
   logic hlt_e = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) hlt_e <= hlt;

   // A new WB entry appears after every edge that did not see hlt.
   always @(negedge clk) begin
      wb_exp_t e;
      if (WB_valid && !hlt_e) begin
         if (sb.size() == 0) check("wb_unexp", 1, 0);
         else begin
            e = sb.pop_front();
            check("wb_we", WB_we, e.we);
            check("wb_dst", WB_dst, e.dst);
            check("wb_pc", WB_PC, e.pc);
            if (e.chk_data) check("wb_data", WB_data, e.data);
         end
      end
   end

   task automatic clear_mem();
      MEM_valid = 0; MEM_mem_rd = 0; MEM_mem_wr = 0;
      MEM_is_branch = 0; MEM_use_dst = 0;
      MEM_flag_ov = 0; MEM_flag_neg = 0; MEM_flag_zero = 0;
      MEM_branch_cond = 0; MEM_addr = 0; MEM_PC = 0;
      MEM_PC_out = 0; MEM_data = 0; MEM_st_data = 0;
   endtask

   task automatic mem_op(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] dst, input logic [21:0] pc,
                         input int ack_dly, input logic [31:0] rdata,
                         input bit hlt_mid,
                         output int stalls, output int reqs);
      wb_exp_t e;
      bit fin;
      fin = 0;
      @(posedge clk); #1;
      MEM_valid = 1; MEM_mem_rd = rd; MEM_mem_wr = wr;
      MEM_data = addr; MEM_st_data = wd; MEM_addr = dst;
      MEM_PC = pc; MEM_use_dst = 1;
      e.we = ~wr; e.dst = dst; e.pc = pc; e.chk_data = ~wr;
      e.data = (ack_dly < 0) ? ERR_DATA : rdata;
      sb.push_back(e);
      stalls = 0; reqs = 0;
      for (int k = 0; k < 300 && !fin; k++) begin
         @(negedge clk);
         if (stall_out) stalls++;
         else fin = 1;
         if (dmem.req) begin
            check("dm_addr", dmem.addr, addr[15:0]);
            check("dm_we", dmem.we, wr);
            if (wr) check("dm_wdata", dmem.wdata, wd);
         end
         if (!fin) begin
            @(posedge clk); #1;
            dmem.ack = 0;
            if (dmem.req) begin
               if (reqs == ack_dly) begin
                  dmem.ack = 1; dmem.rdata = rdata;
               end
               if (hlt_mid && reqs == 1) hlt = 1;
               reqs++;
            end
         end
      end
      if (!fin) check("op_bound", 0, 1);
      @(posedge clk); #1;
      dmem.ack = 0;
      clear_mem();
   endtask

   logic [6:0] bv [11] = '{
      7'b001_001_1, 7'b001_000_0, 7'b000_000_1, 7'b010_000_1,
      7'b010_001_0, 7'b011_010_1, 7'b100_010_0, 7'b101_001_1,
      7'b101_000_0, 7'b110_100_1, 7'b111_000_1
   };

   initial begin
      int st, rq;
      wb_exp_t e;
      clear_mem();
      dmem.ack = 0; dmem.rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", dmem.req, 0);
      check("rst_we", dmem.we, 0);
      check("rst_addr", dmem.addr, 0);
      check("rst_wdata", dmem.wdata, 0);
      check("rst_wbv", WB_valid, 0);
      check("rst_wbwe", WB_we, 0);
      check("rst_wbdst", WB_dst, 0);
      check("rst_wbdata", WB_data, 0);
      check("rst_wbpc", WB_PC, 0);
      check("rst_err", mem_err, 0);
      rst = 0;

      @(posedge clk); #1;
      MEM_valid = 1; MEM_data = 32'h1234; MEM_addr = 5;
      MEM_use_dst = 1; MEM_PC = 22'h100;
      e = '{1'b1, 5'd5, 32'h1234, 22'h100, 1'b1};
      sb.push_back(e);
      @(negedge clk);
      check("alu_stall", stall_out, 0);
      @(posedge clk); #1;
      clear_mem();

      mem_op(1, 0, 32'h40, 0, 7, 22'h200, 3, 32'hCAFEF00D, 0, st, rq);
      check("ld_stalls", st, 4);
      check("ld_reqs", rq, 4);

      mem_op(0, 1, 32'h10, 32'h55, 4, 22'h210, 1, 0, 0, st, rq);
      check("st_stalls", st, 2);

      mem_op(1, 0, 32'h44, 0, 6, 22'h220, 3, 32'hBEEF0001, 1, st, rq);
      repeat (3) begin
         @(negedge clk);
         check("hlt_wb_hold", WB_valid, 0);
      end
      @(posedge clk); #1;
      hlt = 0;
      repeat (2) @(negedge clk);
      #1;
      check("hlt_drain", sb.size(), 0);

      for (int i = 0; i < 11; i++) begin
         logic [6:0] b;
         b = bv[i];
         @(posedge clk); #1;
         MEM_valid = 1; MEM_is_branch = 1;
         MEM_branch_cond = b[6:4];
         MEM_flag_ov = b[3]; MEM_flag_neg = b[2]; MEM_flag_zero = b[1];
         MEM_PC_out = 22'h3FF + 22'(i); MEM_PC = 22'h300 + 22'(i);
         MEM_data = 32'(i);
         e = '{1'b0, 5'd0, 32'(i), 22'h300 + 22'(i), 1'b1};
         sb.push_back(e);
         @(negedge clk);
         check("br_flush", flush_out, b[0]);
         if (b[0]) check("br_target", branch_target, 22'h3FF + 22'(i));
      end
      @(posedge clk); #1;
      clear_mem();
      @(negedge clk);
      check("flush_pulse", flush_out, 0);

      check("err_clean", mem_err, 0);
      mem_op(1, 0, 32'h80, 0, 3, 22'h400, -1, 0, 0, st, rq);
      check("to_reqs", rq, 255);
      check("to_req_drop", dmem.req, 0);
      @(negedge clk);
      check("to_err", mem_err, 1);
      @(posedge clk); #1;
      dmem.ack = 1; dmem.rdata = 32'h12345678;
      @(negedge clk);
      check("late_req", dmem.req, 0);
      check("late_stall", stall_out, 0);
      @(posedge clk); #1;
      dmem.ack = 0;
      @(negedge clk);
      check("late_wbv", WB_valid, 0);
      check("late_err", mem_err, 1);

      @(posedge clk); #1;
      MEM_valid = 1; MEM_mem_rd = 1; MEM_data = 32'h60;
      MEM_addr = 2; MEM_PC = 22'h600;
      repeat (2) @(posedge clk);
      #1;
      check("rstm_req_pre", dmem.req, 1);
      rst = 1;
      clear_mem();
      @(posedge clk); #1;
      check("rstm_req", dmem.req, 0);
      check("rstm_addr", dmem.addr, 0);
      check("rstm_wbv", WB_valid, 0);
      check("rstm_wbdata", WB_data, 0);
      check("rstm_err", mem_err, 0);
      rst = 0;

      mem_op(1, 1, 32'h20, 32'hA5, 9, 22'h500, 0, 32'hFFFF, 0, st, rq);
      @(negedge clk);
      check("rw_err", mem_err, 1);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
